// File: rtl/vm_change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding and
// the value of each coin denomination expressed in 5-unit steps.
package vm_change_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int UNITS_CINCO = 1;
    localparam int UNITS_DIEZ  = 2;

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Request/eject/inventory bundle between the vending FSM side (master)
// and the change dispenser (slave).
interface vm_change_dispenser_if #(
    parameter int AMT_W = 4,
    parameter int INV_W = 8
);
    logic             req_valid;
    logic [AMT_W-1:0] req_units;
    logic             req_ready;
    logic             out_cinco;
    logic             out_diez;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] paid_units;
    logic             refill_cinco;
    logic             refill_diez;
    logic [INV_W-1:0] cnt_cinco;
    logic [INV_W-1:0] cnt_diez;

    modport master (
        output req_valid, req_units, refill_cinco, refill_diez,
        input  req_ready, out_cinco, out_diez, busy, done, short,
               paid_units, cnt_cinco, cnt_diez
    );

    modport slave (
        input  req_valid, req_units, refill_cinco, refill_diez,
        output req_ready, out_cinco, out_diez, busy, done, short,
               paid_units, cnt_cinco, cnt_diez
    );
endinterface

// File: rtl/vm_change_dispenser_coin_counter.sv
// Saturating coin inventory counter: counts up on refill (clamped at the
// maximum), down on eject (never below zero); simultaneous refill and
// eject leave the count unchanged. Resets asynchronously to INIT.
module vm_coin_counter #(
    parameter int INV_W = 8,
    parameter int INIT  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [INV_W-1:0] count,
    output logic             nonzero
);
    localparam logic [INV_W-1:0] MAX_COUNT  = '1;
    localparam logic [INV_W-1:0] INIT_COUNT = INV_W'(INIT);

    logic [INV_W-1:0] count_q, count_d;

    // Next count: saturating increment, floor-at-zero decrement
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != MAX_COUNT) begin
                count_d = count_q + INV_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - INV_W'(1);
            end
        end
    end

    // Inventory register, loaded with the initial stock on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= INIT_COUNT;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: accepts a change amount in 5-unit steps and ejects
// 10 and 5 coins greedily (10 first) as single-cycle pulses, with a
// settle gap after each eject. Define VM_CHANGE_INVENTORY_EN to track
// coin stock, accept refills and flag requests that cannot be paid in full.
module vm_change_dispenser
    import vm_change_dispenser_pkg::*;
#(
    parameter int AMT_W          = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int INV_W          = 8,
    parameter int INV_INIT_CINCO = 20,
    parameter int INV_INIT_DIEZ  = 20
) (
    input logic                 clk,
    input logic                 rst,
    vm_change_dispenser_if.slave bus
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic             sel_diez_q, sel_diez_d;
    logic             short_q, short_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             cinco_avail;
    logic             diez_avail;

`ifdef VM_CHANGE_INVENTORY_EN
    logic eject_cinco;
    logic eject_diez;

    assign eject_cinco = (state_q == ST_EJECT) && !sel_diez_q;
    assign eject_diez  = (state_q == ST_EJECT) && sel_diez_q;

    vm_coin_counter #(.INV_W(INV_W), .INIT(INV_INIT_CINCO)) u_cnt_cinco (
        .clk     (clk),
        .rst     (rst),
        .inc     (bus.refill_cinco),
        .dec     (eject_cinco),
        .count   (bus.cnt_cinco),
        .nonzero (cinco_avail)
    );

    vm_coin_counter #(.INV_W(INV_W), .INIT(INV_INIT_DIEZ)) u_cnt_diez (
        .clk     (clk),
        .rst     (rst),
        .inc     (bus.refill_diez),
        .dec     (eject_diez),
        .count   (bus.cnt_diez),
        .nonzero (diez_avail)
    );
`else
    localparam int unused_inv_init = INV_INIT_CINCO + INV_INIT_DIEZ;
    logic unused_refill;

    assign unused_refill = bus.refill_cinco ^ bus.refill_diez;
    assign cinco_avail   = 1'b1;
    assign diez_avail    = 1'b1;
    assign bus.cnt_cinco = '0;
    assign bus.cnt_diez  = '0;
`endif

    // Greedy selection, eject bookkeeping and settle-gap sequencing
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        paid_d     = paid_q;
        sel_diez_d = sel_diez_q;
        short_d    = short_q;
        gap_d      = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rem_d   = bus.req_units;
                    paid_d  = '0;
                    short_d = 1'b0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_q >= AMT_W'(UNITS_DIEZ) && diez_avail) begin
                    sel_diez_d = 1'b1;
                    state_d    = ST_EJECT;
                end else if (rem_q >= AMT_W'(UNITS_CINCO) && cinco_avail) begin
                    sel_diez_d = 1'b0;
                    state_d    = ST_EJECT;
                end else begin
                    short_d = (rem_q != '0);
                    state_d = ST_DONE;
                end
            end
            ST_EJECT: begin
                if (sel_diez_q) begin
                    rem_d  = rem_q - AMT_W'(UNITS_DIEZ);
                    paid_d = paid_q + AMT_W'(UNITS_DIEZ);
                end else begin
                    rem_d  = rem_q - AMT_W'(UNITS_CINCO);
                    paid_d = paid_q + AMT_W'(UNITS_CINCO);
                end
                gap_d   = GAP_W'(GAP_CYCLES);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            paid_q     <= '0;
            sel_diez_q <= 1'b0;
            short_q    <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            paid_q     <= paid_d;
            sel_diez_q <= sel_diez_d;
            short_q    <= short_d;
            gap_q      <= gap_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.out_diez   = (state_q == ST_EJECT) && sel_diez_q;
    assign bus.out_cinco  = (state_q == ST_EJECT) && !sel_diez_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.short      = (state_q == ST_DONE) && short_q;
    assign bus.paid_units = paid_q;
endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: random change requests and
// refills compared cycle by cycle against a greedy payout/timeline model.
module tb_vm_change_dispenser;
    localparam int AMT_W      = 4;
    localparam int GAP_CYCLES = 4;
    localparam int INV_W      = 8;
    localparam int INV_INIT   = 20;
    localparam int INV_MAX    = (1 << INV_W) - 1;
    localparam int PERIOD     = GAP_CYCLES + 2;
`ifdef VM_CHANGE_INVENTORY_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vm_change_dispenser_if #(.AMT_W(AMT_W), .INV_W(INV_W)) bus ();

    vm_change_dispenser #(
        .AMT_W          (AMT_W),
        .GAP_CYCLES     (GAP_CYCLES),
        .INV_W          (INV_W),
        .INV_INIT_CINCO (INV_INIT),
        .INV_INIT_DIEZ  (INV_INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int m5;
    int m10;
    bit allowRefill;
    int planDen[$];
    bit planRefill[$];
    int planPaid;
    bit planShort;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Greedy payout plan from the current stock: 10s first, then 5s
    function automatic void planRequest(input int units);
        int rem;
        int c5;
        int c10;
        bit refill;
        rem = units;
        c5  = m5;
        c10 = m10;
        planDen.delete();
        planRefill.delete();
        planPaid = 0;
        while (rem > 0) begin
            refill = allowRefill ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rem >= 2 && (!INV_ON || c10 > 0)) begin
                planDen.push_back(2);
                if (!refill) c10--;
            end else if (!INV_ON || c5 > 0) begin
                planDen.push_back(1);
                if (!refill) c5--;
            end else begin
                break;
            end
            rem -= planDen[$];
            planPaid += planDen[$];
            planRefill.push_back(refill);
        end
        planShort = (rem != 0);
    endfunction

    task automatic checkIdleOutputs(input string where);
        checkOutput({where, "_ready"}, bus.req_ready, 1);
        checkOutput({where, "_busy"}, bus.busy, 0);
        checkOutput({where, "_out_diez"}, bus.out_diez, 0);
        checkOutput({where, "_out_cinco"}, bus.out_cinco, 0);
        checkOutput({where, "_done"}, bus.done, 0);
        checkOutput({where, "_cnt_cinco"}, bus.cnt_cinco, INV_ON ? m5 : 0);
        checkOutput({where, "_cnt_diez"}, bus.cnt_diez, INV_ON ? m10 : 0);
    endtask

    // One request from accept to the first idle cycle after done
    task automatic applyStimulus(input int units);
        int k;
        int total;
        int guard;
        int cur5;
        int cur10;
        int p;
        int den;
        bit isPulse;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_at_start", bus.req_ready, 1);
        planRequest(units);
        k = planDen.size();
        total = 2 + k * PERIOD;
        cur5 = m5;
        cur10 = m10;
        bus.req_valid = 1'b1;
        bus.req_units = AMT_W'(units);
        for (int t = 1; t <= total + 1; t++) begin
            @(negedge clk);
            isPulse = 1'b0;
            den = 0;
            p = 0;
            if (t >= 2 && ((t - 2) % PERIOD) == 0 && ((t - 2) / PERIOD) < k) begin
                isPulse = 1'b1;
                p = (t - 2) / PERIOD;
                den = planDen[p];
            end
            checkOutput("out_diez", bus.out_diez, isPulse && den == 2);
            checkOutput("out_cinco", bus.out_cinco, isPulse && den == 1);
            checkOutput("done", bus.done, t == total);
            checkOutput("busy", bus.busy, t <= total);
            checkOutput("req_ready", bus.req_ready, t > total);
            checkOutput("cnt_cinco", bus.cnt_cinco, INV_ON ? cur5 : 0);
            checkOutput("cnt_diez", bus.cnt_diez, INV_ON ? cur10 : 0);
            if (t >= total) begin
                checkOutput("paid_units", bus.paid_units, planPaid);
            end
            if (t == total) begin
                checkOutput("short", bus.short, planShort);
            end
            if (t <= total) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_units = AMT_W'($urandom_range(0, 15));
                bus.refill_cinco = isPulse && den == 1 && planRefill[p];
                bus.refill_diez  = isPulse && den == 2 && planRefill[p];
                if (isPulse && !planRefill[p]) begin
                    if (den == 2) cur10--;
                    else cur5--;
                end
            end else begin
                bus.req_valid = 1'b0;
                bus.refill_cinco = 1'b0;
                bus.refill_diez = 1'b0;
            end
        end
        m5 = cur5;
        m10 = cur10;
    endtask

    // Idle cycles with refill pulses (random, or diez on every cycle)
    task automatic idleCycles(input int n, input bit forceDiez);
        bit r5;
        bit r10;
        for (int i = 0; i < n; i++) begin
            r5  = forceDiez ? 1'b0 : 1'($urandom_range(0, 1));
            r10 = forceDiez ? 1'b1 : 1'($urandom_range(0, 1));
            bus.refill_cinco = r5;
            bus.refill_diez = r10;
            @(negedge clk);
            if (r5) m5 = (m5 < INV_MAX) ? m5 + 1 : INV_MAX;
            if (r10) m10 = (m10 < INV_MAX) ? m10 + 1 : INV_MAX;
            checkIdleOutputs("idle");
        end
        bus.refill_cinco = 1'b0;
        bus.refill_diez = 1'b0;
    endtask

    // Reset asserted during the first settle gap of a 3-unit request
    task automatic resetMidOperation();
        bus.req_valid = 1'b1;
        bus.req_units = AMT_W'(3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        m5 = INV_INIT;
        m10 = INV_INIT;
        checkIdleOutputs("rst_mid");
        checkOutput("rst_mid_paid", bus.paid_units, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkIdleOutputs("after_rst");
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_units = '0;
        bus.refill_cinco = 1'b0;
        bus.refill_diez = 1'b0;
        m5 = INV_INIT;
        m10 = INV_INIT;
        allowRefill = 1'b0;
        #1;
        checkIdleOutputs("reset");
        checkOutput("reset_paid", bus.paid_units, 0);
        checkOutput("reset_short", bus.short, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("post_reset");

        applyStimulus(3);
        applyStimulus(0);

        allowRefill = 1'b1;
        idleCycles(3, 1'b0);
        for (int r = 0; r < 40; r++) begin
            applyStimulus($urandom_range(0, 15));
            idleCycles($urandom_range(0, 3), 1'b0);
        end

`ifdef VM_CHANGE_INVENTORY_EN
        idleCycles(250, 1'b1);
        allowRefill = 1'b0;
        guard = 0;
        while (m5 > 0 && guard < 300) begin
            applyStimulus(1);
            guard++;
        end
        applyStimulus(3);
`endif

        resetMidOperation();
        applyStimulus(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
